// File: rtl/gate5_bist_ctrl.sv
// Built-in self-test sequencer for AND5/OR5 gate cells: walks every input pattern, checks the gate output.
// Define GATE5_BIST_STOP_ON_FAIL_EN to end a run at the first mismatch instead of applying all patterns.
module gate5_bist_ctrl #(
  parameter int N_INPUTS      = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic                dut_o,
  output logic [N_INPUTS-1:0] dut_i,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   fail_cnt,
  output logic [N_INPUTS-1:0] first_fail,
  output logic                first_fail_vld
);

  localparam int CNT_W  = N_INPUTS + 1;
  localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_PAT  = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t              state, next_state;
  logic [N_INPUTS-1:0] pat;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                mode_q;
  logic                expected;
  logic                mismatch;
  logic                stop_run;
  logic [CNT_W-1:0]    fail_cnt_inc;

  assign expected     = mode_q ? (|pat) : (&pat);
  assign mismatch     = (dut_o != expected);
  assign fail_cnt_inc = fail_cnt + CNT_W'(mismatch);

`ifdef GATE5_BIST_STOP_ON_FAIL_EN
  assign stop_run = mismatch;
`else
  assign stop_run = 1'b0;
`endif

  assign dut_i = pat;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE:  if (wait_cnt == '0) next_state = CHECK;
      CHECK:   next_state = ((pat == LAST_PAT) || stop_run) ? DONE : SETTLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pattern, settle timer and result registers; results persist in IDLE until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat            <= '0;
      wait_cnt       <= '0;
      mode_q         <= 1'b0;
      fail_cnt       <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q         <= mode;
            pat            <= '0;
            fail_cnt       <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
            wait_cnt       <= WAIT_LOAD;
          end
        end
        SETTLE: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        CHECK: begin
          fail_cnt <= fail_cnt_inc;
          if (mismatch && !first_fail_vld) begin
            first_fail     <= pat;
            first_fail_vld <= 1'b1;
          end
          if (next_state == DONE) begin
            pass <= (fail_cnt_inc == '0);
          end else begin
            pat      <= pat + N_INPUTS'(1);
            wait_cnt <= WAIT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
